// File: rtl/out_ctrl.sv
// out_ctrl: consumer end of the row-major result stream.
// Buffers incoming results in a small skid FIFO, generates strided
// result-memory addresses and writes each word through a valid/ready
// memory port. Pulses done once all M*P results are written.
// Optional build macro OUT_CTRL_RELU_EN: when defined, the latched relu_en
// clamps negative words to zero as the output register loads.
module out_ctrl #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        sub_scale_M,
  input  logic [7:0]        sub_scale_P,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] row_stride,
  input  logic              relu_en,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_ctrl_ready,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              err_overrun
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t state, state_nxt;

  // Latched job configuration
  logic [7:0]        m_q, p_q;
  logic [ADDR_W-1:0] stride_q;
  logic              relu_q;
  logic [15:0]       total, rx_cnt, xfer_cnt;
  logic              err_q;

  // Skid FIFO
  logic signed [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr, rd_ptr;
  logic [CNT_W-1:0]         fifo_count;

  // Address generator and output stage
  logic [7:0]               col;
  logic [ADDR_W-1:0]        row_base;
  logic                     vld_p1;
  logic [ADDR_W-1:0]        addr_p1;
  logic signed [DATA_W-1:0] wdata_p1;
  logic signed [DATA_W-1:0] head_p0, load_p0;

  logic start_acc, active, fifo_full, fifo_empty, push, drop, pop, xfer;

`ifdef OUT_CTRL_RELU_EN
  function automatic logic signed [DATA_W-1:0] relu_clamp(input logic signed [DATA_W-1:0] x);
    return (x < 0) ? '0 : x;
  endfunction

  assign load_p0 = relu_q ? relu_clamp(head_p0) : head_p0;
`else
  logic unused_relu;
  assign unused_relu = relu_q;
  assign load_p0     = head_p0;
`endif

  assign total      = {8'd0, m_q} * {8'd0, p_q};
  assign start_acc  = start && (state == IDLE);
  assign active     = (state == RUN) || (state == FLUSH);
  assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign push       = in_valid && (state == RUN) && !fifo_full && (rx_cnt != total);
  assign drop       = in_valid && !push;
  assign pop        = active && !fifo_empty && (!vld_p1 || mem_ready);
  assign xfer       = vld_p1 && mem_ready;
  assign head_p0    = fifo_mem[rd_ptr];

  assign out_ctrl_ready = (state == RUN) && (fifo_count <= CNT_W'(FIFO_DEPTH - 2)) &&
                          (rx_cnt < total);
  assign mem_wr_en   = vld_p1;
  assign mem_addr    = addr_p1;
  assign mem_wdata   = wdata_p1;
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign err_overrun = err_q;

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (sub_scale_M == 8'd0 || sub_scale_P == 8'd0) ? DONE : RUN;
      RUN:     if (rx_cnt == total) state_nxt = FLUSH;
      FLUSH:   if ((xfer_cnt + 16'(xfer)) == total) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control state, job configuration, counters and sticky overrun flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      m_q      <= '0;
      p_q      <= '0;
      stride_q <= '0;
      relu_q   <= 1'b0;
      rx_cnt   <= '0;
      xfer_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_acc) begin
        m_q      <= sub_scale_M;
        p_q      <= sub_scale_P;
        stride_q <= row_stride;
        relu_q   <= relu_en;
        rx_cnt   <= '0;
        xfer_cnt <= '0;
      end else begin
        if (push) rx_cnt   <= rx_cnt + 16'd1;
        if (xfer) xfer_cnt <= xfer_cnt + 16'd1;
      end
      err_q <= (err_q && !start_acc) || drop;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop cancel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Stage p0: FIFO storage (data only, no reset)
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= in_data;
  end

  // Stage p1: output register with address generation; holds while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      addr_p1  <= '0;
      wdata_p1 <= '0;
      col      <= '0;
      row_base <= '0;
    end else begin
      if (start_acc) begin
        row_base <= base_addr;
        col      <= '0;
      end
      if (pop) begin
        vld_p1   <= 1'b1;
        addr_p1  <= row_base + ADDR_W'(col);
        wdata_p1 <= load_p0;
        if (col == p_q - 8'd1) begin
          col      <= '0;
          row_base <= row_base + stride_q;
        end else begin
          col <= col + 8'd1;
        end
      end else if (mem_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_out_ctrl.sv
// Scoreboard bench for out_ctrl: the stimulus process pushes each expected
// memory write when it issues the matching input word; a monitor pops and
// compares on every completed memory transfer.
module tb_out_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  sub_scale_M = '0;
  logic [7:0]  sub_scale_P = '0;
  logic [15:0] base_addr = '0;
  logic [15:0] row_stride = '0;
  logic        relu_en = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ctrl_ready;
  logic        mem_wr_en;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b1;
  logic        busy;
  logic        done;
  logic        err_overrun;

  out_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .sub_scale_M(sub_scale_M), .sub_scale_P(sub_scale_P),
    .base_addr(base_addr), .row_stride(row_stride), .relu_en(relu_en),
    .in_valid(in_valid), .in_data(in_data), .out_ctrl_ready(out_ctrl_ready),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .busy(busy), .done(done), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] a;
    logic [31:0] d;
  } wr_t;

  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          rdy_mode = 0;
  int          pc = 0;
  wr_t         sb[$];
  logic [15:0] ea[$];
  logic [31:0] ed[$];
  logic [31:0] din[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Main-process time base: 3 time units after the falling edge
  task automatic tick();
    @(negedge clk);
    #3;
  endtask

  // Memory acceptance pattern: always ready, or repeating 1,0,0,1
  always @(negedge clk) begin
    mem_ready = (rdy_mode == 0) ? 1'b1 : ((pc % 4) == 0 || (pc % 4) == 3);
    pc++;
  end

  // Monitor: compares completed transfers and stall stability
  logic        st_flag = 1'b0;
  logic [15:0] st_a;
  logic [31:0] st_d;
  wr_t         e;
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      st_flag = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (st_flag) begin
        check("stall_hold_en", {31'd0, mem_wr_en}, 32'd1);
        check("stall_hold_addr", {16'd0, mem_addr}, {16'd0, st_a});
        check("stall_hold_data", mem_wdata, st_d);
      end
      st_flag = 1'b0;
      if (mem_wr_en) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write", mem_addr, mem_wdata);
        end else if (mem_ready) begin
          e = sb.pop_front();
          check("wr_addr", {16'd0, mem_addr}, {16'd0, e.a});
          check("wr_data", mem_wdata, e.d);
        end else begin
          st_flag = 1'b1;
          st_a    = mem_addr;
          st_d    = mem_wdata;
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {31'd0, out_ctrl_ready}, 32'd0);
    check({tag, "_wr_en"}, {31'd0, mem_wr_en}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_err"}, {31'd0, err_overrun}, 32'd0);
    check({tag, "_addr"}, {16'd0, mem_addr}, 32'd0);
    check({tag, "_wdata"}, mem_wdata, 32'd0);
  endtask

  task automatic clear_tabs();
    din.delete();
    ea.delete();
    ed.delete();
  endtask

  task automatic run_job(input logic [7:0] m, input logic [7:0] p,
                         input logic [15:0] base, input logic [15:0] stride,
                         input logic relu, input int extra, input int abort_after,
                         input logic exp_err, input int max_lat);
    int   idx = 0;
    int   cyc = 0;
    int   lat = 1;
    int   d0;
    logic rdy_prev = 1'b0;
    wr_t  w;
    sub_scale_M = m;
    sub_scale_P = p;
    base_addr   = base;
    row_stride  = stride;
    relu_en     = relu;
    start       = 1'b1;
    d0          = done_cnt;
    tick();
    start = 1'b0;
    // Scramble the configuration inputs: the job must use the latched copy
    sub_scale_M = 8'd9;
    sub_scale_P = 8'd9;
    base_addr   = 16'h5555;
    row_stride  = 16'h3333;
    relu_en     = ~relu;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("err_clear_on_start", {31'd0, err_overrun}, 32'd0);
    while (idx < din.size() && cyc < 3000 && !(abort_after >= 0 && idx == abort_after)) begin
      in_valid = rdy_prev;
      if (rdy_prev) begin
        in_data = din[idx];
        if (idx < ea.size()) begin
          w.a = ea[idx];
          w.d = ed[idx];
          sb.push_back(w);
        end
        idx++;
      end
      rdy_prev = out_ctrl_ready;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    if (cyc >= 3000) begin
      checks++;
      errors++;
      $display("FAIL stream_timeout: sent %0d of %0d words", idx, din.size());
    end
    if (extra > 0) begin
      in_valid = 1'b1;
      in_data  = 32'hDEAD_BEEF;
      tick();
      in_valid = 1'b0;
    end
    if (abort_after >= 0) begin
      rst_n = 1'b0;
      sb.delete();
      #1;
      check_reset_outputs("abort");
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      return;
    end
    while (done_cnt == d0 && lat < 3000) begin
      tick();
      lat++;
    end
    if (done_cnt == d0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done pulse, required one");
    end
    check("done_latency_ok", {31'd0, lat <= max_lat}, 32'd1);
    repeat (3) tick();
    check("done_pulses", done_cnt - d0, 32'd1);
    check("all_writes_seen", sb.size(), 32'd0);
    check("err_overrun", {31'd0, err_overrun}, {31'd0, exp_err});
    check("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Basic 2x3 job, hand table
    clear_tabs();
    din = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
    ea  = '{16'h0100, 16'h0101, 16'h0102, 16'h0110, 16'h0111, 16'h0112};
    ed  = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
    run_job(8'd2, 8'd3, 16'h0100, 16'h0010, 1'b0, 0, -1, 1'b0, 3000);

    // 8x8 job under memory backpressure 1,0,0,1
    clear_tabs();
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        din.push_back(32'h1000 + 32'(r * 8 + c));
        ea.push_back(16'h2000 + 16'(r * 16'h0020) + 16'(c));
        ed.push_back(32'h1000 + 32'(r * 8 + c));
      end
    end
    rdy_mode = 1;
    run_job(8'd8, 8'd8, 16'h2000, 16'h0020, 1'b0, 0, -1, 1'b0, 3000);
    rdy_mode = 0;

    // Zero size: no writes, done within two cycles
    clear_tabs();
    run_job(8'd0, 8'd5, 16'h0300, 16'h0010, 1'b0, 0, -1, 1'b0, 2);

    // Overrun: third word after two accepted words is dropped
    clear_tabs();
    din = '{32'hA1, 32'hA2};
    ea  = '{16'h0400, 16'h0401};
    ed  = '{32'hA1, 32'hA2};
    run_job(8'd1, 8'd2, 16'h0400, 16'h0008, 1'b0, 1, -1, 1'b1, 3000);
    repeat (4) tick();
    check("err_sticky", {31'd0, err_overrun}, 32'd1);

    // Address wrap (also checks err clears on this start)
    clear_tabs();
    din = '{32'h11, 32'h22, 32'h33, 32'h44};
    ea  = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    ed  = '{32'h11, 32'h22, 32'h33, 32'h44};
    run_job(8'd1, 8'd4, 16'hFFFE, 16'h0001, 1'b0, 0, -1, 1'b0, 3000);

    // ReLU request: clamps only when the feature is built in
    clear_tabs();
    din = '{32'hFFFF_FFF6, 32'h0000_0007};
    ea  = '{16'h0500, 16'h0501};
`ifdef OUT_CTRL_RELU_EN
    ed  = '{32'h0000_0000, 32'h0000_0007};
`else
    ed  = '{32'hFFFF_FFF6, 32'h0000_0007};
`endif
    run_job(8'd1, 8'd2, 16'h0500, 16'h0040, 1'b1, 0, -1, 1'b0, 3000);

    // Reset after 3 of 6 words, then a clean job
    clear_tabs();
    din = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
    ea  = '{16'h0100, 16'h0101, 16'h0102, 16'h0110, 16'h0111, 16'h0112};
    ed  = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
    run_job(8'd2, 8'd3, 16'h0100, 16'h0010, 1'b0, 0, 3, 1'b0, 3000);
    check_reset_outputs("post_abort");
    clear_tabs();
    din = '{32'h71, 32'h72, 32'h73, 32'h74, 32'h75, 32'h76};
    ea  = '{16'h0600, 16'h0601, 16'h0602, 16'h0680, 16'h0681, 16'h0682};
    ed  = '{32'h71, 32'h72, 32'h73, 32'h74, 32'h75, 32'h76};
    run_job(8'd2, 8'd3, 16'h0600, 16'h0080, 1'b0, 0, -1, 1'b0, 3000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/out_ctrl.md
Name: out_ctrl

Overview:
- Consumer end of the serialized result stream produced by the output alignment stage, which drains results row-major: P columns per row, M rows.
- Accepts 32-bit results under a valid/ready handshake and absorbs the producer's one-cycle ready-to-valid latency with a small skid FIFO.
- Generates strided result-memory addresses, writes the results through a valid/ready memory port, and pulses done when all M*P results are written.

Parameters:
- DATA_W, 32, result word width.
- ADDR_W, 16, result memory address width.
- FIFO_DEPTH, 4, skid FIFO entries; power of two, minimum 4.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; latches the job configuration
- sub_scale_M  in  8  rows in the sub-matrix
- sub_scale_P  in  8  columns in the sub-matrix
- base_addr  in  ADDR_W  address of element (0,0)
- row_stride  in  ADDR_W  address increment per row
- relu_en  in  1  clamp negative results to zero (used only with OUT_CTRL_RELU_EN)
- in_valid  in  1  input word present this cycle
- in_data  in  DATA_W  input word, valid in the same cycle as in_valid
- out_ctrl_ready  out  1  consumer can accept; producer reacts one cycle later
- mem_wr_en  out  1  memory write request, held until accepted
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  DATA_W  write data
- mem_ready  in  1  memory accepts the write this cycle
- busy  out  1  job in progress
- done  out  1  one-cycle completion pulse
- err_overrun  out  1  sticky error: a word arrived that could not be stored

Behaviour:
- Reset (async, rst_n low):
  - outputs: out_ctrl_ready, mem_wr_en, busy, done and err_overrun = 0; mem_addr and mem_wdata = 0.
  - internal: FIFO empty, all counters 0, state IDLE.
- States: IDLE, RUN, FLUSH, DONE.
- IDLE:
  - start latches M, P, base_addr, row_stride and relu_en, and clears err_overrun.
  - If M==0 or P==0, go to DONE with no writes. Otherwise go to RUN.
  - start is ignored in every state other than IDLE.
- RUN:
  - out_ctrl_ready = (fifo_count <= FIFO_DEPTH-2) && (rx_cnt < M*P).
  - in_valid pushes in_data and increments rx_cnt (16 bits).
  - When rx_cnt reaches M*P, go to FLUSH.
- Overrun, in any state:
  - in_valid while the FIFO is full, or while rx_cnt==M*P, or outside RUN: the word is dropped and err_overrun is set.
  - err_overrun stays set until the next accepted start.
- Write side (RUN and FLUSH):
  - The output register loads from the FIFO head when the FIFO is non-empty and (mem_wr_en==0 or mem_ready==1).
  - mem_wr_en, mem_addr and mem_wdata are registered and stay stable while mem_wr_en=1 and mem_ready=0.
  - A transfer completes on a cycle with mem_wr_en && mem_ready.
- Address generation:
  - mem_addr = row_base + col, with row_base starting at base_addr.
  - col increments per loaded word. At col==P-1, col returns to 0 and row_base += row_stride.
  - All arithmetic is modulo 2^ADDR_W; wrap-around is silent.
- Latency: a word sampled at edge E0 can drive mem_wr_en after edge E1 at the earliest.
- Throughput: one word per cycle when mem_ready is held high.
- Completion:
  - In FLUSH, once the M*P-th memory transfer completes, go to DONE.
  - DONE asserts done for exactly one cycle, then returns to IDLE.
- busy = 1 in RUN, FLUSH and DONE.
- Simultaneous push and pop on the same cycle leave fifo_count unchanged.
- Reset mid-job aborts immediately. No partial state survives the reset.

Optional Feature:
- Macro: OUT_CTRL_RELU_EN.
- Defined: when the latched relu_en=1, a word with in_data[DATA_W-1]==1 is written as 0 (the clamp is applied as the output register loads). Latency is unchanged.
- Undefined: the relu_en port exists but is ignored, and data is written unmodified.

Test Plan:
- Basic 2x3 job: M=2, P=3, base=0x100, stride=0x10, mem_ready=1, data 1..6 streamed back-to-back.
  -> writes (0x100,1) (0x101,2) (0x102,3) (0x110,4) (0x111,5) (0x112,6); done pulses once; err_overrun=0.
- Memory backpressure: 8x8 job with mem_ready toggling 1,0,0,1.
  -> out_ctrl_ready drops when fifo_count reaches 3; all 64 words written in order; no drops; addr and data stable during stalls.
- Zero size: start with M=0, P=5.
  -> done pulses 2 cycles after start; mem_wr_en never asserted.
- Overrun: M=1, P=2, with a third in_valid pulse after two accepted words.
  -> exactly 2 writes; err_overrun=1 until the next start.
- Address wrap: base=0xFFFE, stride=1, M=1, P=4.
  -> addresses FFFE, FFFF, 0000, 0001.
- ReLU (macro defined, relu_en=1): data 0xFFFFFFF6, 0x00000007.
  -> writes 0x00000000, 0x00000007. Same stimulus with the macro undefined writes the data unchanged.
- Reset mid-job: drive rst_n low after 3 of 6 words of a job.
  -> all outputs return to 0; a new job runs correctly afterwards.
